sdram_read: RTL and testbench
=============================

// Module: sdram_read
// PURPOSE
//  Read-side SDRAM engine: pairs with the write engine on the same arbiter and command bus.
//  After rd_trig, streams RD_BURSTS bursts of 4 words from bank 0, starting at row 0 / col 0.
//  Captured data goes into the read FIFO, low byte only.
//  Yields to auto-refresh or a nearly-full FIFO at burst boundaries, then re-requests and resumes.
// PARAMETERS
//  CAS_LAT    3     CAS latency (2 or 3) in s_clk cycles, RD command -> first data word
//  T_RCD      3     cycles from ACT to first RD (RD_ACT length = T_RCD+1)
//  T_RP       3     cycles spent in RD_PRE after PRECHAR
//  RD_BURSTS  1024  bursts per transaction (power of 2, <= 2^14)
// PORTS
//  s_clk          in   1   system/SDRAM clock
//  s_rst          in   1   asynchronous, active-high reset
//  rd_trig        in   1   pulse: start a new read transaction (sampled in RD_IDLE only)
//  en_rd          in   1   arbiter grant; sampled in RD_REQ
//  req_rd         out  1   request to arbiter (high in RD_REQ)
//  rd_end         out  1   1-cycle pulse: bus released (done or refresh/FIFO yield)
//  req_aref       in   1   refresh pending; honoured at burst boundary
//  rd_cmd         out  4   {CS_n,RAS_n,CAS_n,WE_n}: ACT=0011 RD=0101 PRECHAR=0010 NOP=0111
//  rd_addr        out  12  row during ACT, {3'b0,col} during RD, bit10=1 during PRECHAR
//  rd_bank        out  2   constant 2'b00
//  sdram_dq       in   16  SDRAM data bus
//  rfifo_wr_en    out  1   write strobe to read FIFO
//  rfifo_wr_data  out  8   sdram_dq[7:0], registered
//  rfifo_afull    in   1   FIFO cannot accept 4 more words beyond in-flight data
// BEHAVIOUR
//  Reset: state RD_IDLE; rd_cmd=NOP; rd_addr=0; req_rd=0; rd_end=0; rfifo_wr_en=0.
//   rfifo_wr_data=0; all counters and the capture pipe cleared. Reset mid-burst drops in-flight data.
//  FSM (one-hot):
//   RD_IDLE -> RD_REQ on rd_trig. Clears row/col/burst counters and the done flag.
//   RD_REQ -> RD_ACT on en_rd.
//   RD_ACT: ACT on cnt_act==0 (rd_addr=row) -> READ when cnt_act==T_RCD.
//   READ: RD on cnt_burst==0, rd_addr={3'b0,col}; NOP otherwise.
//    cnt_burst counts 0..3 and wraps.
//    -> RD_PRE at cnt_burst==3 if any of: last burst issued, req_aref, rfifo_afull, col==508.
//   RD_PRE: PRECHAR (A10=1) on cnt_pre==0, then NOP. At cnt_pre==T_RP:
//    done -> RD_IDLE.
//    req_aref or rfifo_afull -> RD_REQ; rd_end pulses.
//    otherwise (row change) -> RD_ACT directly, keeping the bus.
//  Addressing:
//   col advances by 4 per RD issued (9-bit).
//   After the RD at col 508, col wraps to 0 and row increments (12-bit, wraps 4095->0).
//   Counters persist across refresh yields; resume reissues ACT for the current row.
//  Completion: burst counter (log2 RD_BURSTS+1 bits) counts RDs; done is set when it hits RD_BURSTS.
//   rd_end pulses on the RD_PRE->RD_IDLE cycle. Later rd_trig pulses are ignored until RD_IDLE.
//  Capture: shift register of depth CAS_LAT+4 tracks each RD.
//   rfifo_wr_en is high exactly 4 consecutive cycles, starting CAS_LAT+1 cycles after the RD
//   appears on rd_cmd (+1 for the input register).
//   Capture runs independently of state, so bursts in flight while in RD_PRE are still written.
//   PRECHAR never truncates a burst.
//  req_aref and rfifo_afull arriving together: one exit; both handled by the same RD_REQ return.
//  req_aref high while in RD_ACT: ignored until the first burst boundary in READ.
//   At least one burst per grant guarantees forward progress.
// STRUCTURE
//  Shared package sdram_pkg: command encodings (ACT/RD/PRECHAR/NOP), state encodings, ROW_W=12, COL_W=9.
//  One sub-module: sdram_rd_capture (CAS_LAT delay pipe + data register -> rfifo_wr_en/rfifo_wr_data).
// TESTING
//  1 RD_BURSTS=2, CAS_LAT=3, model returns dq=addr:
//    ACT@row0; RD@col0 and RD@col4 4 cycles apart; PRECHAR; one rd_end;
//    8 FIFO writes of 0..7, each 4 cycles after its RD.
//  2 req_aref asserted mid-burst 3 of 4:
//    exit after cnt_burst==3; PRECHAR; rd_end; req_rd high; after en_rd, ACT same row, RD col 12.
//  3 RD_BURSTS=256 from col 0:
//    RD at col 508, PRECHAR, ACT row 1 without rd_end/req_rd; next RD col 0.
//  4 rfifo_afull held high during first burst:
//    exactly 1 RD issued; its 4 words are still written after PRECHAR; returns to RD_REQ.
//  5 s_rst pulsed 1 cycle after an RD:
//    all outputs reset immediately; no rfifo_wr_en follows; FSM idle until the next rd_trig.
//  6 CAS_LAT=2: rfifo_wr_en window moves one cycle earlier versus scenario 1; data unchanged.

Source files
------------

// File: rtl/sdram_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sdram_pkg                                                    |
// | Description : Shared SDRAM command encodings, address widths, FSM states.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package sdram_pkg;

    localparam int ROW_W = 12;
    localparam int COL_W = 9;
    localparam int DQ_W  = 16;

    // {CS_n, RAS_n, CAS_n, WE_n}
    localparam logic [3:0] c_cmd_act = 4'b0011;
    localparam logic [3:0] c_cmd_rd  = 4'b0101;
    localparam logic [3:0] c_cmd_pre = 4'b0010;
    localparam logic [3:0] c_cmd_nop = 4'b0111;

    localparam logic [ROW_W-1:0] c_addr_pre = 12'h400;
    localparam logic [COL_W-1:0] c_col_last = 9'd508;

    typedef enum logic [4:0] {
        RD_IDLE = 5'b00001,
        RD_REQ  = 5'b00010,
        RD_ACT  = 5'b00100,
        READ    = 5'b01000,
        RD_PRE  = 5'b10000
    } rd_state_e;

endpackage
`default_nettype wire

// File: rtl/sdram_rd_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sdram_rd_capture                                             |
// | Description : Tracks issued RDs through CAS latency and writes the low     |
// |               byte of each returned word into the read FIFO.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sdram_rd_capture
    import sdram_pkg::*;
#(
    parameter int CAS_LAT = 3
) (
    input  logic            s_clk,
    input  logic            s_rst,
    input  logic            i_rd_issue,
    input  logic [DQ_W-1:0] i_dq,
    output logic            o_wr_en,
    output logic [7:0]      o_wr_data
);

    localparam int DEPTH = CAS_LAT + 4;

    logic [DEPTH-1:0] r_pipe_q;
    logic [DEPTH-1:0] w_pipe_d;
    logic [7:0]       r_data_q;
    logic [7:0]       w_data_d;
    logic             w_unused_dq;

    assign w_unused_dq = ^i_dq[DQ_W-1:8];

    always_comb begin
        w_pipe_d = {r_pipe_q[DEPTH-2:0], i_rd_issue};
        w_data_d = i_dq[7:0];
    end

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            r_pipe_q <= '0;
            r_data_q <= '0;
        end else begin
            r_pipe_q <= w_pipe_d;
            r_data_q <= w_data_d;
        end
    end

    // Four taps past CAS latency cover the burst plus the input register stage.
    assign o_wr_en   = |r_pipe_q[DEPTH-1:CAS_LAT];
    assign o_wr_data = r_data_q;

endmodule
`default_nettype wire

// File: rtl/sdram_read.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sdram_read                                                   |
// | Description : Read-side SDRAM engine streaming 4-word bursts from bank 0   |
// |               into the read FIFO, yielding for refresh or FIFO back-off.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sdram_read
    import sdram_pkg::*;
#(
    parameter int CAS_LAT   = 3,
    parameter int T_RCD     = 3,
    parameter int T_RP      = 3,
    parameter int RD_BURSTS = 1024
) (
    input  logic             s_clk,
    input  logic             s_rst,
    input  logic             rd_trig,
    input  logic             en_rd,
    output logic             req_rd,
    output logic             rd_end,
    input  logic             req_aref,
    output logic [3:0]       rd_cmd,
    output logic [ROW_W-1:0] rd_addr,
    output logic [1:0]       rd_bank,
    input  logic [DQ_W-1:0]  sdram_dq,
    output logic             rfifo_wr_en,
    output logic [7:0]       rfifo_wr_data,
    input  logic             rfifo_afull
);

    localparam int BCNT_W   = $clog2(RD_BURSTS) + 1;
    localparam int WAIT_MAX = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int WAIT_W   = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

    rd_state_e          r_state_q,   w_state_d;
    logic [WAIT_W-1:0]  r_cnt_act_q, w_cnt_act_d;
    logic [WAIT_W-1:0]  r_cnt_pre_q, w_cnt_pre_d;
    logic [1:0]         r_beat_q,    w_beat_d;
    logic [COL_W-1:0]   r_col_q,     w_col_d;
    logic [ROW_W-1:0]   r_row_q,     w_row_d;
    logic [BCNT_W-1:0]  r_bcnt_q,    w_bcnt_d;
    logic               r_done_q,    w_done_d;
    logic               r_yield_q,   w_yield_d;

    logic [BCNT_W-1:0]  w_bcnt_inc;
    logic [3:0]         w_rd_cmd;
    logic [ROW_W-1:0]   w_rd_addr;
    logic               w_req_rd;
    logic               w_rd_end;
    logic               w_rd_issue;

    assign w_bcnt_inc = r_bcnt_q + BCNT_W'(1);

    always_comb begin
        w_state_d   = r_state_q;
        w_cnt_act_d = r_cnt_act_q;
        w_cnt_pre_d = r_cnt_pre_q;
        w_beat_d    = r_beat_q;
        w_col_d     = r_col_q;
        w_row_d     = r_row_q;
        w_bcnt_d    = r_bcnt_q;
        w_done_d    = r_done_q;
        w_yield_d   = r_yield_q;
        w_rd_cmd    = c_cmd_nop;
        w_rd_addr   = '0;
        w_req_rd    = 1'b0;
        w_rd_end    = 1'b0;
        w_rd_issue  = 1'b0;

        case (r_state_q)
            RD_IDLE: begin
                if (rd_trig) begin
                    w_state_d = RD_REQ;
                    w_col_d   = '0;
                    w_row_d   = '0;
                    w_bcnt_d  = '0;
                    w_done_d  = 1'b0;
                    w_yield_d = 1'b0;
                end
            end
            RD_REQ: begin
                w_req_rd = 1'b1;
                if (en_rd) begin
                    w_state_d   = RD_ACT;
                    w_cnt_act_d = '0;
                end
            end
            RD_ACT: begin
                if (r_cnt_act_q == '0) begin
                    w_rd_cmd  = c_cmd_act;
                    w_rd_addr = r_row_q;
                end
                if (r_cnt_act_q == WAIT_W'(T_RCD)) begin
                    w_state_d   = READ;
                    w_cnt_act_d = '0;
                    w_beat_d    = '0;
                end else begin
                    w_cnt_act_d = r_cnt_act_q + WAIT_W'(1);
                end
            end
            READ: begin
                if (r_beat_q == 2'd0) begin
                    w_rd_cmd   = c_cmd_rd;
                    w_rd_addr  = {{(ROW_W-COL_W){1'b0}}, r_col_q};
                    w_rd_issue = 1'b1;
                    w_col_d    = r_col_q + COL_W'(4);
                    if (r_col_q == c_col_last) begin
                        w_row_d = r_row_q + ROW_W'(1);
                    end
                    w_bcnt_d = w_bcnt_inc;
                    if (w_bcnt_inc == BCNT_W'(RD_BURSTS)) begin
                        w_done_d = 1'b1;
                    end
                end
                w_beat_d = r_beat_q + 2'd1;
                // col reads back as 0 at the boundary only after the RD at col 508 wrapped it.
                if ((r_beat_q == 2'd3) &&
                    (r_done_q || req_aref || rfifo_afull || (r_col_q == '0))) begin
                    w_state_d   = RD_PRE;
                    w_cnt_pre_d = '0;
                    w_yield_d   = req_aref | rfifo_afull;
                end
            end
            RD_PRE: begin
                if (r_cnt_pre_q == '0) begin
                    w_rd_cmd  = c_cmd_pre;
                    w_rd_addr = c_addr_pre;
                end
                if (r_cnt_pre_q == WAIT_W'(T_RP)) begin
                    w_cnt_pre_d = '0;
                    if (r_done_q) begin
                        w_state_d = RD_IDLE;
                        w_rd_end  = 1'b1;
                    end else if (r_yield_q) begin
                        w_state_d = RD_REQ;
                        w_rd_end  = 1'b1;
                    end else begin
                        w_state_d   = RD_ACT;
                        w_cnt_act_d = '0;
                    end
                end else begin
                    w_cnt_pre_d = r_cnt_pre_q + WAIT_W'(1);
                end
            end
            default: begin
                w_state_d = RD_IDLE;
            end
        endcase
    end

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            r_state_q   <= RD_IDLE;
            r_cnt_act_q <= '0;
            r_cnt_pre_q <= '0;
            r_beat_q    <= '0;
            r_col_q     <= '0;
            r_row_q     <= '0;
            r_bcnt_q    <= '0;
            r_done_q    <= 1'b0;
            r_yield_q   <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_cnt_act_q <= w_cnt_act_d;
            r_cnt_pre_q <= w_cnt_pre_d;
            r_beat_q    <= w_beat_d;
            r_col_q     <= w_col_d;
            r_row_q     <= w_row_d;
            r_bcnt_q    <= w_bcnt_d;
            r_done_q    <= w_done_d;
            r_yield_q   <= w_yield_d;
        end
    end

    assign rd_cmd  = w_rd_cmd;
    assign rd_addr = w_rd_addr;
    assign rd_bank = 2'b00;
    assign req_rd  = w_req_rd;
    assign rd_end  = w_rd_end;

    sdram_rd_capture #(
        .CAS_LAT (CAS_LAT)
    ) u_capture (
        .s_clk     (s_clk),
        .s_rst     (s_rst),
        .i_rd_issue(w_rd_issue),
        .i_dq      (sdram_dq),
        .o_wr_en   (rfifo_wr_en),
        .o_wr_data (rfifo_wr_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_sdram_read.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sdram_read                                                |
// | Description : Directed bench for sdram_read: three instances (2 bursts,    |
// |               256 bursts, CAS 2) against a dq=column SDRAM model.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_sdram_read;

    localparam int K_ACT = 0;
    localparam int K_RD  = 1;
    localparam int K_PRE = 2;
    localparam int K_END = 3;
    localparam int K_WR  = 4;
    localparam int K_REQ = 5;

    typedef struct {
        int dut;
        int kind;
        int cyc;
        int val;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rd_trig = 1'b0;
    logic en_rd = 1'b0;
    logic req_aref = 1'b0;
    logic afull = 1'b0;

    logic [2:0]        req_rd, rd_end, wr_en;
    logic [2:0][3:0]   cmd;
    logic [2:0][11:0]  addr;
    logic [2:0][1:0]   bank;
    logic [2:0][15:0]  dq;
    logic [2:0][7:0]   wdata;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    ev_t  evq[$];
    logic [15:0] sched [3][64];
    bit          sv    [3][64];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sdram_read #(.CAS_LAT(3), .T_RCD(3), .T_RP(3), .RD_BURSTS(2)) u_dut0 (
        .s_clk(clk), .s_rst(rst), .rd_trig(rd_trig), .en_rd(en_rd), .req_rd(req_rd[0]),
        .rd_end(rd_end[0]), .req_aref(req_aref), .rd_cmd(cmd[0]), .rd_addr(addr[0]),
        .rd_bank(bank[0]), .sdram_dq(dq[0]), .rfifo_wr_en(wr_en[0]),
        .rfifo_wr_data(wdata[0]), .rfifo_afull(afull));

    sdram_read #(.CAS_LAT(3), .T_RCD(3), .T_RP(3), .RD_BURSTS(256)) u_dut1 (
        .s_clk(clk), .s_rst(rst), .rd_trig(rd_trig), .en_rd(en_rd), .req_rd(req_rd[1]),
        .rd_end(rd_end[1]), .req_aref(req_aref), .rd_cmd(cmd[1]), .rd_addr(addr[1]),
        .rd_bank(bank[1]), .sdram_dq(dq[1]), .rfifo_wr_en(wr_en[1]),
        .rfifo_wr_data(wdata[1]), .rfifo_afull(afull));

    sdram_read #(.CAS_LAT(2), .T_RCD(3), .T_RP(3), .RD_BURSTS(2)) u_dut2 (
        .s_clk(clk), .s_rst(rst), .rd_trig(rd_trig), .en_rd(en_rd), .req_rd(req_rd[2]),
        .rd_end(rd_end[2]), .req_aref(req_aref), .rd_cmd(cmd[2]), .rd_addr(addr[2]),
        .rd_bank(bank[2]), .sdram_dq(dq[2]), .rfifo_wr_en(wr_en[2]),
        .rfifo_wr_data(wdata[2]), .rfifo_afull(afull));

    function automatic void log_ev(input int d, input int k, input int v);
        ev_t e;
        e.dut = d; e.kind = k; e.cyc = cyc; e.val = v;
        evq.push_back(e);
    endfunction

    // SDRAM model returns the column address on dq, word k at RD + CAS + k.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            int lat;
            int slot;
            lat = (i == 2) ? 2 : 3;
            if (cmd[i] == 4'b0101) begin
                for (int k = 0; k < 4; k++) begin
                    slot = (cyc + lat + k) % 64;
                    sched[i][slot] = 16'(addr[i]) + 16'(k);
                    sv[i][slot]    = 1'b1;
                end
            end
            slot  = cyc % 64;
            dq[i] = sv[i][slot] ? sched[i][slot] : 16'hbeef;
            sv[i][slot] = 1'b0;
            if (!rst) begin
                if (cmd[i] == 4'b0011) log_ev(i, K_ACT, int'(addr[i]));
                if (cmd[i] == 4'b0101) log_ev(i, K_RD,  int'(addr[i]));
                if (cmd[i] == 4'b0010) log_ev(i, K_PRE, int'(addr[i]));
                if (rd_end[i])         log_ev(i, K_END, 0);
                if (wr_en[i])          log_ev(i, K_WR,  int'(wdata[i]));
                if (req_rd[i])         log_ev(i, K_REQ, 0);
            end
        end
    end

    function automatic int count_ev(input int d, input int k);
        int n = 0;
        foreach (evq[j]) if (evq[j].dut == d && evq[j].kind == k) n++;
        return n;
    endfunction

    function automatic void get_ev(input int d, input int k, input int n,
                                   output int c, output int v);
        int seen = 0;
        c = -1; v = -1;
        foreach (evq[j]) begin
            if (evq[j].dut == d && evq[j].kind == k) begin
                if (seen == n) begin
                    c = evq[j].cyc; v = evq[j].val;
                    return;
                end
                seen++;
            end
        end
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_ev(input int d, input int k, input int n, input int budget,
                           output bit ok);
        int t = 0;
        while (count_ev(d, k) < n && t < budget) begin
            tick(1);
            t++;
        end
        ok = (count_ev(d, k) >= n);
    endtask

    task automatic do_rst();
        rd_trig = 1'b0; req_aref = 1'b0; afull = 1'b0; en_rd = 1'b0;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
        evq.delete();
    endtask

    task automatic start_run();
        evq.delete();
        rd_trig = 1'b1;
        tick(1);
        rd_trig = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(2);
        for (int i = 0; i < 3; i++) begin
            total++; if (cmd[i] !== 4'b0111) begin bad++; $display("FAIL reset_cmd dut%0d got=%b exp=0111", i, cmd[i]); end
            total++; if (addr[i] !== 12'h000) begin bad++; $display("FAIL reset_addr dut%0d got=%h exp=000", i, addr[i]); end
            total++; if (req_rd[i] !== 1'b0) begin bad++; $display("FAIL reset_req dut%0d got=%b exp=0", i, req_rd[i]); end
            total++; if (rd_end[i] !== 1'b0) begin bad++; $display("FAIL reset_end dut%0d got=%b exp=0", i, rd_end[i]); end
            total++; if (wr_en[i] !== 1'b0) begin bad++; $display("FAIL reset_wren dut%0d got=%b exp=0", i, wr_en[i]); end
            total++; if (wdata[i] !== 8'h00) begin bad++; $display("FAIL reset_wdata dut%0d got=%h exp=00", i, wdata[i]); end
            total++; if (bank[i] !== 2'b00) begin bad++; $display("FAIL reset_bank dut%0d got=%b exp=00", i, bank[i]); end
        end
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_basic();
        int ca, va, c0, v0, c1, v1, cp, vp, ce, ve, cw, vw, d0w, d2w;
        do_rst();
        en_rd = 1'b1;
        start_run();
        tick(10);
        rd_trig = 1'b1;
        tick(1);
        rd_trig = 1'b0;
        tick(40);
        total++; if (count_ev(0, K_ACT) !== 1) begin bad++; $display("FAIL basic_act_count got=%0d exp=1", count_ev(0, K_ACT)); end
        get_ev(0, K_ACT, 0, ca, va);
        total++; if (va !== 0) begin bad++; $display("FAIL basic_act_row got=%0d exp=0", va); end
        total++; if (count_ev(0, K_RD) !== 2) begin bad++; $display("FAIL basic_rd_count got=%0d exp=2", count_ev(0, K_RD)); end
        get_ev(0, K_RD, 0, c0, v0);
        get_ev(0, K_RD, 1, c1, v1);
        total++; if (v0 !== 0) begin bad++; $display("FAIL basic_rd0_col got=%0d exp=0", v0); end
        total++; if (v1 !== 4) begin bad++; $display("FAIL basic_rd1_col got=%0d exp=4", v1); end
        total++; if (c0 - ca !== 4) begin bad++; $display("FAIL basic_act_to_rd got=%0d exp=4", c0 - ca); end
        total++; if (c1 - c0 !== 4) begin bad++; $display("FAIL basic_rd_spacing got=%0d exp=4", c1 - c0); end
        get_ev(0, K_PRE, 0, cp, vp);
        total++; if (vp !== 12'h400) begin bad++; $display("FAIL basic_pre_addr got=%h exp=400", vp); end
        total++; if (cp !== c1 + 4) begin bad++; $display("FAIL basic_pre_time got=%0d exp=%0d", cp, c1 + 4); end
        total++; if (count_ev(0, K_END) !== 1) begin bad++; $display("FAIL basic_end_count got=%0d exp=1", count_ev(0, K_END)); end
        get_ev(0, K_END, 0, ce, ve);
        total++; if (ce !== cp + 3) begin bad++; $display("FAIL basic_end_time got=%0d exp=%0d", ce, cp + 3); end
        total++; if (count_ev(0, K_WR) !== 8) begin bad++; $display("FAIL basic_wr_count got=%0d exp=8", count_ev(0, K_WR)); end
        for (int k = 0; k < 8; k++) begin
            get_ev(0, K_WR, k, cw, vw);
            total++; if (vw !== k) begin bad++; $display("FAIL basic_wr%0d_data got=%0d exp=%0d", k, vw, k); end
            total++; if (cw !== ((k < 4) ? c0 : c1) + 4 + k % 4) begin bad++; $display("FAIL basic_wr%0d_time got=%0d exp=%0d", k, cw, ((k < 4) ? c0 : c1) + 4 + k % 4); end
        end
        // CAS 2 instance saw identical stimulus
        get_ev(2, K_RD, 0, c0, v0);
        get_ev(2, K_RD, 1, c1, v1);
        total++; if (count_ev(2, K_WR) !== 8) begin bad++; $display("FAIL cl2_wr_count got=%0d exp=8", count_ev(2, K_WR)); end
        for (int k = 0; k < 8; k++) begin
            get_ev(2, K_WR, k, cw, vw);
            total++; if (vw !== k) begin bad++; $display("FAIL cl2_wr%0d_data got=%0d exp=%0d", k, vw, k); end
            total++; if (cw !== ((k < 4) ? c0 : c1) + 3 + k % 4) begin bad++; $display("FAIL cl2_wr%0d_time got=%0d exp=%0d", k, cw, ((k < 4) ? c0 : c1) + 3 + k % 4); end
        end
        get_ev(0, K_WR, 0, d0w, vw);
        get_ev(2, K_WR, 0, d2w, vw);
        total++; if (d0w - d2w !== 1) begin bad++; $display("FAIL cl2_window_shift got=%0d exp=1", d0w - d2w); end
    endtask

    task automatic test_refresh();
        bit ok;
        int c2, v2, cp, vp, ce, ve, ca, va, c3, v3;
        do_rst();
        en_rd = 1'b1;
        start_run();
        wait_ev(1, K_RD, 3, 100, ok);
        total++; if (!ok) begin bad++; $display("FAIL aref_wait_rd3 got=%0d exp=3", count_ev(1, K_RD)); end
        req_aref = 1'b1;
        en_rd = 1'b0;
        wait_ev(1, K_END, 1, 50, ok);
        total++; if (!ok) begin bad++; $display("FAIL aref_wait_end got=%0d exp=1", count_ev(1, K_END)); end
        req_aref = 1'b0;
        tick(3);
        total++; if (req_rd[1] !== 1'b1) begin bad++; $display("FAIL aref_req_rd got=%b exp=1", req_rd[1]); end
        total++; if (count_ev(1, K_RD) !== 3) begin bad++; $display("FAIL aref_rd_count got=%0d exp=3", count_ev(1, K_RD)); end
        get_ev(1, K_RD, 2, c2, v2);
        get_ev(1, K_PRE, 0, cp, vp);
        get_ev(1, K_END, 0, ce, ve);
        total++; if (v2 !== 8) begin bad++; $display("FAIL aref_rd3_col got=%0d exp=8", v2); end
        total++; if (cp !== c2 + 4) begin bad++; $display("FAIL aref_pre_time got=%0d exp=%0d", cp, c2 + 4); end
        total++; if (ce !== cp + 3) begin bad++; $display("FAIL aref_end_time got=%0d exp=%0d", ce, cp + 3); end
        en_rd = 1'b1;
        tick(12);
        total++; if (count_ev(1, K_ACT) !== 2) begin bad++; $display("FAIL aref_act_count got=%0d exp=2", count_ev(1, K_ACT)); end
        get_ev(1, K_ACT, 1, ca, va);
        get_ev(1, K_RD, 3, c3, v3);
        total++; if (va !== 0) begin bad++; $display("FAIL aref_resume_row got=%0d exp=0", va); end
        total++; if (v3 !== 12) begin bad++; $display("FAIL aref_resume_col got=%0d exp=12", v3); end
        total++; if (c3 - ca !== 4) begin bad++; $display("FAIL aref_resume_rcd got=%0d exp=4", c3 - ca); end
    endtask

    task automatic test_row_wrap();
        int cr, vr, cp, vp, ca, va, cn, vn;
        do_rst();
        en_rd = 1'b1;
        start_run();
        tick(600);
        get_ev(1, K_RD, 127, cr, vr);
        get_ev(1, K_PRE, 0, cp, vp);
        get_ev(1, K_ACT, 1, ca, va);
        get_ev(1, K_RD, 128, cn, vn);
        total++; if (vr !== 508) begin bad++; $display("FAIL wrap_last_col got=%0d exp=508", vr); end
        total++; if (cp !== cr + 4) begin bad++; $display("FAIL wrap_pre_time got=%0d exp=%0d", cp, cr + 4); end
        total++; if (va !== 1) begin bad++; $display("FAIL wrap_act_row got=%0d exp=1", va); end
        total++; if (ca !== cp + 4) begin bad++; $display("FAIL wrap_act_time got=%0d exp=%0d", ca, cp + 4); end
        total++; if (vn !== 0) begin bad++; $display("FAIL wrap_next_col got=%0d exp=0", vn); end
        total++; if (cn - ca !== 4) begin bad++; $display("FAIL wrap_next_rcd got=%0d exp=4", cn - ca); end
        total++; if (count_ev(1, K_END) !== 0) begin bad++; $display("FAIL wrap_no_end got=%0d exp=0", count_ev(1, K_END)); end
        total++; if (count_ev(1, K_REQ) !== 1) begin bad++; $display("FAIL wrap_req_cycles got=%0d exp=1", count_ev(1, K_REQ)); end
    endtask

    task automatic test_afull();
        bit ok;
        int cr, vr, cp, vp, ce, ve, cw, vw;
        do_rst();
        en_rd = 1'b1;
        afull = 1'b1;
        start_run();
        wait_ev(0, K_ACT, 1, 20, ok);
        total++; if (!ok) begin bad++; $display("FAIL afull_wait_act got=%0d exp=1", count_ev(0, K_ACT)); end
        en_rd = 1'b0;
        tick(30);
        afull = 1'b0;
        total++; if (count_ev(0, K_RD) !== 1) begin bad++; $display("FAIL afull_rd_count got=%0d exp=1", count_ev(0, K_RD)); end
        get_ev(0, K_RD, 0, cr, vr);
        get_ev(0, K_PRE, 0, cp, vp);
        get_ev(0, K_END, 0, ce, ve);
        total++; if (cp !== cr + 4) begin bad++; $display("FAIL afull_pre_time got=%0d exp=%0d", cp, cr + 4); end
        total++; if (count_ev(0, K_WR) !== 4) begin bad++; $display("FAIL afull_wr_count got=%0d exp=4", count_ev(0, K_WR)); end
        for (int k = 0; k < 4; k++) begin
            get_ev(0, K_WR, k, cw, vw);
            total++; if (vw !== k) begin bad++; $display("FAIL afull_wr%0d_data got=%0d exp=%0d", k, vw, k); end
        end
        get_ev(0, K_WR, 3, cw, vw);
        total++; if (cw !== cp + 3) begin bad++; $display("FAIL afull_wr_after_pre got=%0d exp=%0d", cw, cp + 3); end
        total++; if (count_ev(0, K_END) !== 1) begin bad++; $display("FAIL afull_end_count got=%0d exp=1", count_ev(0, K_END)); end
        total++; if (ce !== cp + 3) begin bad++; $display("FAIL afull_end_time got=%0d exp=%0d", ce, cp + 3); end
        total++; if (req_rd[0] !== 1'b1) begin bad++; $display("FAIL afull_back_to_req got=%b exp=1", req_rd[0]); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_rst();
        en_rd = 1'b1;
        start_run();
        wait_ev(0, K_RD, 1, 20, ok);
        total++; if (!ok) begin bad++; $display("FAIL rstmid_wait_rd got=%0d exp=1", count_ev(0, K_RD)); end
        rst = 1'b1;
        #1;
        total++; if (cmd[0] !== 4'b0111) begin bad++; $display("FAIL rstmid_cmd got=%b exp=0111", cmd[0]); end
        total++; if (req_rd[0] !== 1'b0) begin bad++; $display("FAIL rstmid_req got=%b exp=0", req_rd[0]); end
        total++; if (wr_en[0] !== 1'b0) begin bad++; $display("FAIL rstmid_wren got=%b exp=0", wr_en[0]); end
        tick(1);
        rst = 1'b0;
        tick(20);
        total++; if (count_ev(0, K_WR) !== 0) begin bad++; $display("FAIL rstmid_no_write got=%0d exp=0", count_ev(0, K_WR)); end
        total++; if (count_ev(0, K_ACT) !== 1) begin bad++; $display("FAIL rstmid_idle_act got=%0d exp=1", count_ev(0, K_ACT)); end
        total++; if (req_rd[0] !== 1'b0) begin bad++; $display("FAIL rstmid_idle_req got=%b exp=0", req_rd[0]); end
        start_run();
        tick(10);
        total++; if (count_ev(0, K_ACT) !== 1) begin bad++; $display("FAIL rstmid_restart_act got=%0d exp=1", count_ev(0, K_ACT)); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_refresh();
        test_row_wrap();
        test_afull();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
